// File: rtl/comparator_pkg.sv
// Shared definitions for comparator response checkers: sweep FSM states,
// the flag triple a comparator reports, and the golden unsigned compare.
package comparator_pkg;

  // Widest operand the golden compare accepts; narrower operands are zero-extended.
  localparam int unsigned MAX_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRIVE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } bist_state_t;

  typedef struct packed {
    logic e;
    logic g;
    logic l;
  } cmp_flags_t;

  // Reference response of an ideal unsigned magnitude comparator.
  function automatic cmp_flags_t golden_compare(input logic [MAX_W-1:0] a,
                                                input logic [MAX_W-1:0] b);
    cmp_flags_t f;
    f.e = (a == b);
    f.g = (a > b);
    f.l = (a < b);
    return f;
  endfunction

endpackage

// File: rtl/comparator_golden.sv
// Combinational golden model of a WIDTH-bit unsigned comparator. Fed the
// operands currently presented to the comparator under test.
module comparator_golden
  import comparator_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             exp_e,
  output logic             exp_g,
  output logic             exp_l
);

  cmp_flags_t flags;

  // Evaluate the ideal response for the current operand pair.
  always_comb begin
    flags = golden_compare(MAX_W'(a), MAX_W'(b));
  end

  assign exp_e = flags.e;
  assign exp_g = flags.g;
  assign exp_l = flags.l;

endmodule

// File: rtl/comparator_2bit_bist.sv
// On-chip response checker for a WIDTH-bit comparator. A start pulse sweeps
// every {a,b} pair in ascending order, waits SETTLE cycles per vector, then
// compares e/g/l with the golden model. Reports a saturating error count,
// the first failing vector and an overall pass flag.
module comparator_2bit_bist
  import comparator_pkg::*;
#(
  parameter int WIDTH  = 2,
  parameter int SETTLE = 1,
  parameter int ERR_W  = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [WIDTH-1:0]     a_out,
  output logic [WIDTH-1:0]     b_out,
  input  logic                 e_in,
  input  logic                 g_in,
  input  logic                 l_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_W-1:0]     err_count,
  output logic [2*WIDTH-1:0]   first_fail_vec,
  output logic                 first_fail_valid
);

  localparam int VW = 2 * WIDTH;
  // One spare bit so the terminal vector is compared explicitly, never wrapped.
  localparam int CW = VW + 1;
  localparam logic [CW-1:0]    LAST_VEC    = CW'((1 << VW) - 1);
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0]    SETTLE_LAST = SW'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;

  bist_state_t      state;
  logic [CW-1:0]    vec;
  logic [SW-1:0]    settle_cnt;
  logic             exp_e;
  logic             exp_g;
  logic             exp_l;
  logic             mismatch;
  logic [ERR_W-1:0] err_inc;

  comparator_golden #(
    .WIDTH (WIDTH)
  ) u_golden (
    .a     (a_out),
    .b     (b_out),
    .exp_e (exp_e),
    .exp_g (exp_g),
    .exp_l (exp_l)
  );

  // Flag any difference from the golden triple and form the saturated next count.
  // NOTE: every signal written here gets a value on every path, so no latch is inferred.
  always_comb begin
    mismatch = (e_in != exp_e) || (g_in != exp_g) || (l_in != exp_l);
    err_inc  = (err_count == ERR_MAX) ? err_count : err_count + ERR_W'(1);
  end

  // Sweep FSM with registered operands, status flags and result registers.
  // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      vec              <= '0;
      settle_cnt       <= '0;
      a_out            <= '0;
      b_out            <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          // Operands keep their last value until the first new vector is driven.
          if (start) begin
            state            <= ST_DRIVE;
            vec              <= '0;
            err_count        <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
            busy             <= 1'b1;
            done             <= 1'b0;
            pass             <= 1'b0;
          end
        end

        ST_DRIVE: begin
          {a_out, b_out} <= vec[VW-1:0];
          settle_cnt     <= '0;
          state          <= (SETTLE == 0) ? ST_CHECK : ST_WAIT;
        end

        ST_WAIT: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= ST_CHECK;
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end

        ST_CHECK: begin
          if (mismatch) begin
            err_count <= err_inc;
            if (!first_fail_valid) begin
              first_fail_vec   <= vec[VW-1:0];
              first_fail_valid <= 1'b1;
            end
          end
          if (vec == LAST_VEC) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            // Saturation never wraps to zero, so this equals (final err_count == 0).
            pass  <= !mismatch && (err_count == '0);
          end else begin
            vec   <= vec + CW'(1);
            state <= ST_DRIVE;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          pass  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comparator_2bit_bist.sv
// Bench for comparator_2bit_bist: attaches a comparator with selectable faults,
// predicts every output cycle by cycle from the sweep timing rules, and pins
// the prediction with hand-computed results for known faults.
module tb_comparator_2bit_bist;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] a_out, b_out;
  logic       e_in, g_in, l_in;
  logic       busy, done, pass;
  logic [4:0] err_count;
  logic [3:0] first_fail_vec;
  logic       first_fail_valid;

  // Second instance with a 2-bit error counter and a dead comparator.
  logic [1:0] s_a, s_b;
  logic       s_busy, s_done, s_pass;
  logic [1:0] s_err;
  logic [3:0] s_ffv;
  logic       s_ffvalid;

  int n_vec  = 0;
  int n_miss = 0;

  // Fault mode of the attached comparator: 0 good, 1 g stuck 0, 2 g/l swapped, 3 random flips.
  int               mode = 0;
  logic [15:0][2:0] rmask;
  logic [2:0]       cur_mask;

  always #5 clk = ~clk;

  comparator_2bit_bist dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .a_out            (a_out),
    .b_out            (b_out),
    .e_in             (e_in),
    .g_in             (g_in),
    .l_in             (l_in),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .err_count        (err_count),
    .first_fail_vec   (first_fail_vec),
    .first_fail_valid (first_fail_valid)
  );

  comparator_2bit_bist #(.ERR_W(2)) dut_sat (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .a_out            (s_a),
    .b_out            (s_b),
    .e_in             (1'b0),
    .g_in             (1'b0),
    .l_in             (1'b0),
    .busy             (s_busy),
    .done             (s_done),
    .pass             (s_pass),
    .err_count        (s_err),
    .first_fail_vec   (s_ffv),
    .first_fail_valid (s_ffvalid)
  );

  // Response of the attached (possibly faulty) comparator, as {e,g,l}.
  function automatic logic [2:0] attached_resp(input int md, input int a, input int b,
                                               input logic [2:0] msk);
    logic e, g, l;
    e = (a == b);
    g = (a > b);
    l = (a < b);
    case (md)
      1:       return {e, 1'b0, l};
      2:       return {e, l, g};
      3:       return {e, g, l} ^ msk;
      default: return {e, g, l};
    endcase
  endfunction

  assign cur_mask = rmask[{a_out, b_out}];
  assign {e_in, g_in, l_in} = attached_resp(mode, int'(a_out), int'(b_out), cur_mask);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Timing model: k counts clock edges since the accepted start (-1 = never started).
  // Vector v is driven at edge 3v+1 and judged at edge 3v+3; sweep ends at edge 48.
  int               k      = -1;
  int               m_ab   = 0;
  int               m_mode = 0;
  logic [15:0][2:0] m_mask = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k    <= -1;
      m_ab <= 0;
    end else if (start && (k < 0 || k == 48)) begin
      k      <= 0;
      m_mode <= mode;
      m_mask <= rmask;
    end else if (k >= 0 && k < 48) begin
      k    <= k + 1;
      m_ab <= k / 3;
    end
  end

  function automatic bit m_fail(input int v);
    int a, b;
    logic [2:0] ideal;
    a     = v / 4;
    b     = v % 4;
    ideal = {a == b, a > b, a < b};
    return attached_resp(m_mode, a, b, m_mask[v]) != ideal;
  endfunction

  // {busy, done, pass, ffvalid, a, b, err_count, first_fail_vec}
  function automatic logic [16:0] expected_outputs();
    int nchk, errs, ff;
    bit bz, dn;
    nchk = (k < 0) ? 0 : k / 3;
    errs = 0;
    ff   = -1;
    for (int v = 0; v < nchk; v++) begin
      if (m_fail(v)) begin
        errs++;
        if (ff < 0) ff = v;
      end
    end
    if (errs > 31) errs = 31;
    bz = (k >= 0) && (k < 48);
    dn = (k == 48);
    return {bz, dn, dn && (errs == 0), ff >= 0, 4'(m_ab), 5'(errs), 4'((ff < 0) ? 0 : ff)};
  endfunction

  // Compare every DUT output with the model on each falling edge.
  always @(negedge clk) begin
    check("cycle", 32'({busy, done, pass, first_fail_valid, a_out, b_out,
                        err_count, first_fail_vec}), 32'(expected_outputs()));
  end

  // One sweep; optional second start pulse dup_at cycles in. Checks busy-to-done latency.
  task automatic run_sweep(input int dup_at);
    int n;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_rise", busy, 1);
    n = 0;
    while (!done && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (n == dup_at) begin
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n++;
      end
    end
    check("latency", n, 48);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rmask = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {busy, done, pass, first_fail_valid, a_out, b_out,
                            err_count, first_fail_vec}, 0);
    rst_n = 1'b1;

    // Good comparator.
    mode = 0;
    run_sweep(0);
    check("good_pass", pass, 1);
    check("good_err", err_count, 0);
    check("good_ffvalid", first_fail_valid, 0);
    check("good_hold_ab", {a_out, b_out}, 4'hf);
    check("sat_done", s_done, 1);
    check("sat_err", s_err, 3);
    check("sat_ffv", s_ffv, 4'b0000);
    check("sat_ffvalid", s_ffvalid, 1);
    check("sat_pass", s_pass, 0);

    // g stuck at 0: fails on the six a>b pairs.
    mode = 1;
    run_sweep(0);
    check("gs0_err", err_count, 6);
    check("gs0_ffv", first_fail_vec, 4'b0100);
    check("gs0_ffvalid", first_fail_valid, 1);
    check("gs0_pass", pass, 0);

    // g/l swapped: fails on all twelve unequal pairs.
    mode = 2;
    run_sweep(0);
    check("swap_err", err_count, 12);
    check("swap_ffv", first_fail_vec, 4'b0001);
    check("swap_pass", pass, 0);

    // Extra start 10 cycles into the sweep is ignored.
    mode = 0;
    run_sweep(10);
    check("dup_pass", pass, 1);
    check("dup_err", err_count, 0);

    // Reset mid-sweep after one error has been recorded.
    mode = 1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    check("pre_rst_err", err_count, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_status", {busy, done, pass, first_fail_valid}, 0);
    check("rst_ab", {a_out, b_out}, 0);
    check("rst_err", err_count, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mode  = 0;
    run_sweep(0);
    check("post_rst_pass", pass, 1);

    // Random fault patterns with random idle gaps and stray start pulses.
    for (int s = 0; s < 8; s++) begin
      mode = 3;
      for (int v = 0; v < 16; v++) begin
        rmask[v] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      end
      repeat ($urandom_range(0, 4)) @(posedge clk);
      #1;
      run_sweep(int'($urandom_range(0, 40)));
    end

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
